// File: rtl/asc2ps2_tx.sv
// Device-side PS/2 keyboard emulator: ASCII in, set-2 make + break frames out on ps2_clk/ps2_data.
// Optional: define ASC2PS2_SHIFT_EN to wrap uppercase letters in left-shift make/break codes.
module asc2ps2_tx #(
    parameter int HALF_CYC = 4,
    parameter int GAP_CYC  = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       asc_valid,
    input  logic [7:0] asc_data,
    output logic       asc_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       done,
    output logic       unmapped
);
    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    localparam int CMAX = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic           phase;      // 0: ps2_clk high half, 1: ps2_clk low half
    logic [3:0]     bit_idx;
    logic [2:0]     byte_idx;
    logic [7:0]     code_q;
    logic [7:0]     cur_byte;
    logic [7:0]     lc;
    logic [8:0]     map_res;
    logic           half_end, bit_end, frame_end, gap_end, last_byte, accept;

    function automatic logic [8:0] lookup(input logic [7:0] c);
        logic [8:0] r;
        r = 9'h000;
        case (c)
            8'h61: r = {1'b1, 8'h1C};  8'h62: r = {1'b1, 8'h32};  8'h63: r = {1'b1, 8'h21};
            8'h64: r = {1'b1, 8'h23};  8'h65: r = {1'b1, 8'h24};  8'h66: r = {1'b1, 8'h2B};
            8'h67: r = {1'b1, 8'h34};  8'h68: r = {1'b1, 8'h33};  8'h69: r = {1'b1, 8'h43};
            8'h6A: r = {1'b1, 8'h3B};  8'h6B: r = {1'b1, 8'h42};  8'h6C: r = {1'b1, 8'h4B};
            8'h6D: r = {1'b1, 8'h3A};  8'h6E: r = {1'b1, 8'h31};  8'h6F: r = {1'b1, 8'h44};
            8'h70: r = {1'b1, 8'h4D};  8'h71: r = {1'b1, 8'h15};  8'h72: r = {1'b1, 8'h2D};
            8'h73: r = {1'b1, 8'h1B};  8'h74: r = {1'b1, 8'h2C};  8'h75: r = {1'b1, 8'h3C};
            8'h76: r = {1'b1, 8'h2A};  8'h77: r = {1'b1, 8'h1D};  8'h78: r = {1'b1, 8'h22};
            8'h79: r = {1'b1, 8'h35};  8'h7A: r = {1'b1, 8'h1A};
            8'h30: r = {1'b1, 8'h45};  8'h31: r = {1'b1, 8'h16};  8'h32: r = {1'b1, 8'h1E};
            8'h33: r = {1'b1, 8'h26};  8'h34: r = {1'b1, 8'h25};  8'h35: r = {1'b1, 8'h2E};
            8'h36: r = {1'b1, 8'h36};  8'h37: r = {1'b1, 8'h3D};  8'h38: r = {1'b1, 8'h3E};
            8'h39: r = {1'b1, 8'h46};
            8'h08: r = {1'b1, 8'h66};  8'h09: r = {1'b1, 8'h0D};  8'h0D: r = {1'b1, 8'h5A};
            8'h1B: r = {1'b1, 8'h76};  8'h20: r = {1'b1, 8'h29};
            8'h3B: r = {1'b1, 8'h4C};  8'h3D: r = {1'b1, 8'h55};  8'h2C: r = {1'b1, 8'h41};
            8'h2D: r = {1'b1, 8'h4E};  8'h2E: r = {1'b1, 8'h49};  8'h2F: r = {1'b1, 8'h4A};
            8'h60: r = {1'b1, 8'h0E};  8'h5B: r = {1'b1, 8'h54};  8'h5D: r = {1'b1, 8'h5B};
            8'h5C: r = {1'b1, 8'h5D};  8'h27: r = {1'b1, 8'h52};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    // Uppercase folds onto the lowercase scan code; shift wrapping (if any) is added below.
    assign lc        = (asc_data >= 8'h41 && asc_data <= 8'h5A) ? (asc_data | 8'h20) : asc_data;
    assign map_res   = lookup(lc);
    assign accept    = asc_valid && (state == IDLE);
    assign half_end  = (cnt == CW'(HALF_CYC - 1));
    assign bit_end   = half_end && phase;
    assign frame_end = bit_end && (bit_idx == 4'd10);
    assign gap_end   = (cnt == CW'(GAP_CYC - 1));

`ifdef ASC2PS2_SHIFT_EN
    logic shift_q;
    logic is_upper;
    assign is_upper  = (asc_data >= 8'h41 && asc_data <= 8'h5A);
    assign last_byte = (byte_idx == (shift_q ? 3'd5 : 3'd2));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                 shift_q <= 1'b0;
        else if (accept && map_res[8]) shift_q <= is_upper;
    end

    always_comb begin
        cur_byte = code_q;
        if (shift_q) begin
            case (byte_idx)
                3'd0, 3'd5: cur_byte = 8'h12;
                3'd2, 3'd4: cur_byte = 8'hF0;
                default:    cur_byte = code_q;
            endcase
        end else if (byte_idx == 3'd1) begin
            cur_byte = 8'hF0;
        end
    end
`else
    assign last_byte = (byte_idx == 3'd2);
    assign cur_byte  = (byte_idx == 3'd1) ? 8'hF0 : code_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            cnt      <= '0;
            phase    <= 1'b0;
            bit_idx  <= 4'd0;
            byte_idx <= 3'd0;
            code_q   <= 8'h00;
            done     <= 1'b0;
            unmapped <= 1'b0;
        end else begin
            state    <= state_nx;
            done     <= (state == GAP) && gap_end && last_byte;
            unmapped <= accept && !map_res[8];
            if (accept && map_res[8]) code_q <= map_res[7:0];
            case (state)
                FRAME: begin
                    cnt <= half_end ? '0 : cnt + 1'b1;
                    if (half_end) phase <= ~phase;
                    if (bit_end)  bit_idx <= frame_end ? 4'd0 : bit_idx + 4'd1;
                end
                GAP: begin
                    cnt <= gap_end ? '0 : cnt + 1'b1;
                    if (gap_end) byte_idx <= byte_idx + 3'd1;
                end
                default: begin
                    cnt      <= '0;
                    phase    <= 1'b0;
                    bit_idx  <= 4'd0;
                    byte_idx <= 3'd0;
                end
            endcase
        end
    end

    // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && map_res[8]) state_nx = FRAME;
            FRAME:   if (frame_end) state_nx = GAP;
            GAP:     if (gap_end) state_nx = last_byte ? IDLE : FRAME;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        asc_ready = (state == IDLE);
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        if (state == FRAME) begin
            ps2_clk = ~phase;
            case (bit_idx)
                4'd0:    ps2_data = 1'b0;
                4'd9:    ps2_data = ~^cur_byte;
                4'd10:   ps2_data = 1'b1;
                default: ps2_data = cur_byte[bit_idx[2:0] - 3'd1];
            endcase
        end
    end
endmodule
